// File: rtl/stream_demux_pkg.sv
`default_nettype none
// ============================================================================
// stream_demux_pkg : FSM state encoding and select-width helper for stream_demux
// Revision 1.0
// ============================================================================
package stream_demux_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PKT  = 2'd1,
        DROP = 2'd2
    } state_t;

    function automatic int sel_w(input int n);
        return $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_demux_slice.sv
`default_nettype none
// ============================================================================
// stream_demux_slice : one-entry valid/ready register slice carrying data+last
// Revision 1.0
// ============================================================================
module stream_demux_slice #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_i,
    input  logic [DW-1:0] data_i,
    input  logic          last_i,
    input  logic          ready_i,
    output logic          can_accept_o,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    output logic          last_o
);

    logic          valid_q, valid_d;
    logic [DW-1:0] data_q,  data_d;
    logic          last_q,  last_d;

    // Refill in the same cycle the held beat drains keeps full throughput.
    assign can_accept_o = !valid_q || ready_i;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        if (wr_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            last_d  = last_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign last_o  = last_q && valid_q;

endmodule
`default_nettype wire

// File: rtl/stream_demux.sv
`default_nettype none
// ============================================================================
// stream_demux : 1-to-N packet demultiplexer, select locked per packet.
// Optional macro STREAM_DEMUX_DROP_CNT_EN adds a saturating drop_cnt port.
// Revision 1.0
// ============================================================================
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter  int N_OUT = 2,
    parameter  int DW    = 8,
    localparam int SEL_W = sel_w(N_OUT)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SEL_W-1:0]    sel,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DW-1:0]       in_data,
    input  logic                in_last,
    output logic [N_OUT-1:0]    out_valid,
    input  logic [N_OUT-1:0]    out_ready,
    output logic [N_OUT*DW-1:0] out_data,
    output logic [N_OUT-1:0]    out_last,
    output logic                drop
`ifdef STREAM_DEMUX_DROP_CNT_EN
    ,
    output logic [15:0]         drop_cnt
`endif
);

    localparam logic [SEL_W:0] c_n_out = (SEL_W+1)'(N_OUT);

    state_t             state_q;
    logic [SEL_W-1:0]   cur_sel_q;
    logic               drop_q;

    logic [SEL_W-1:0]   w_route_sel;
    logic               w_sel_ok;
    logic               w_tgt_rdy;
    logic               w_beat;
    logic               w_route;
    logic               w_discard;
    logic [N_OUT-1:0]   w_slice_rdy;
    logic [N_OUT-1:0]   w_wr;

    assign w_sel_ok    = ({1'b0, sel} < c_n_out);
    assign w_route_sel = (state_q == PKT) ? cur_sel_q : sel;

    // Loop compare rather than direct index so an out-of-range sel never indexes.
    always_comb begin
        w_tgt_rdy = 1'b0;
        for (int k = 0; k < N_OUT; k++) begin
            if (w_route_sel == SEL_W'(k)) begin
                w_tgt_rdy = w_slice_rdy[k];
            end
        end
    end

    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            IDLE:    in_ready = w_sel_ok ? w_tgt_rdy : 1'b1;
            PKT:     in_ready = w_tgt_rdy;
            DROP:    in_ready = 1'b1;
            default: in_ready = 1'b0;
        endcase
    end

    assign w_beat    = in_valid && in_ready;
    assign w_route   = w_beat && (((state_q == IDLE) && w_sel_ok) || (state_q == PKT));
    assign w_discard = w_beat && (((state_q == IDLE) && !w_sel_ok) || (state_q == DROP));

    always_comb begin
        w_wr = '0;
        for (int k = 0; k < N_OUT; k++) begin
            w_wr[k] = w_route && (w_route_sel == SEL_W'(k));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cur_sel_q <= '0;
            drop_q    <= 1'b0;
        end else begin
            drop_q <= w_discard;
            case (state_q)
                IDLE: begin
                    if (w_beat) begin
                        if (w_sel_ok) begin
                            cur_sel_q <= sel;
                            if (!in_last) state_q <= PKT;
                        end else if (!in_last) begin
                            state_q <= DROP;
                        end
                    end
                end
                PKT:     if (w_beat && in_last) state_q <= IDLE;
                DROP:    if (w_beat && in_last) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign drop = drop_q;

    generate
        for (genvar k = 0; k < N_OUT; k++) begin : g_slice
            stream_demux_slice #(
                .DW (DW)
            ) u_slice (
                .clk          (clk),
                .rst_n        (rst_n),
                .wr_i         (w_wr[k]),
                .data_i       (in_data),
                .last_i       (in_last),
                .ready_i      (out_ready[k]),
                .can_accept_o (w_slice_rdy[k]),
                .valid_o      (out_valid[k]),
                .data_o       (out_data[k*DW +: DW]),
                .last_o       (out_last[k])
            );
        end
    endgenerate

`ifdef STREAM_DEMUX_DROP_CNT_EN
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= 16'd0;
        end else if (w_discard && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_demux.sv
`default_nettype none
// ============================================================================
// tb_stream_demux : directed and random checks of stream_demux (N_OUT=5, DW=8)
// Revision 1.0
// ============================================================================
module tb_stream_demux;

    // N_OUT=5 gives a 3-bit sel, so sel=5..7 are representable bad selects.
    localparam int NO = 5;
    localparam int DW = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [2:0]        sel;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     in_data;
    logic              in_last;
    logic [NO-1:0]     out_valid;
    logic [NO-1:0]     out_ready;
    logic [NO*DW-1:0]  out_data;
    logic [NO-1:0]     out_last;
    logic              drop;
`ifdef STREAM_DEMUX_DROP_CNT_EN
    logic [15:0]       drop_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    stream_demux #(
        .N_OUT (NO),
        .DW    (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .drop      (drop)
`ifdef STREAM_DEMUX_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = '0;
        sel       = '0;
        out_ready = '1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        n_checks++;
        if (out_valid !== 5'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 00000", out_valid); end
        n_checks++;
        if (out_last !== 5'b0) begin n_fail++; $display("FAIL reset_out_last got %b want 00000", out_last); end
        n_checks++;
        if (out_data !== 40'h0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", out_data); end
        n_checks++;
        if (drop !== 1'b0) begin n_fail++; $display("FAIL reset_drop got %b want 0", drop); end
`ifdef STREAM_DEMUX_DROP_CNT_EN
        n_checks++;
        if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_drop_cnt got %0d want 0", drop_cnt); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] d [3];
        d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = d[i]; in_last = (i == 2); sel = 3'd2;
            #1;
            n_checks++;
            if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready beat %0d got %b want 1", i, in_ready); end
            tick();
            n_checks++;
            if (out_valid !== 5'b00100) begin n_fail++; $display("FAIL basic_out_valid beat %0d got %b want 00100", i, out_valid); end
            n_checks++;
            if (out_data[2*DW +: DW] !== d[i]) begin n_fail++; $display("FAIL basic_data beat %0d got %h want %h", i, out_data[2*DW +: DW], d[i]); end
            n_checks++;
            if (out_last !== ((i == 2) ? 5'b00100 : 5'b00000)) begin n_fail++; $display("FAIL basic_last beat %0d got %b", i, out_last); end
        end
        idle_inputs();
        tick();
        n_checks++;
        if (out_valid !== 5'b0) begin n_fail++; $display("FAIL basic_drain got %b want 00000", out_valid); end
    endtask

    task automatic test_sel_change();
        logic [7:0] d [5];
        logic [2:0] s [5];
        logic       l [5];
        logic [2:0] ch [5];
        d[0] = 8'h41; s[0] = 3'd1; l[0] = 1'b0; ch[0] = 3'd1;
        d[1] = 8'h42; s[1] = 3'd3; l[1] = 1'b0; ch[1] = 3'd1;
        d[2] = 8'h43; s[2] = 3'd3; l[2] = 1'b1; ch[2] = 3'd1;
        d[3] = 8'h44; s[3] = 3'd3; l[3] = 1'b1; ch[3] = 3'd3;
        d[4] = 8'h45; s[4] = 3'd0; l[4] = 1'b1; ch[4] = 3'd0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = d[i]; in_last = l[i]; sel = s[i];
            tick();
            n_checks++;
            if (out_valid !== (5'b1 << ch[i])) begin n_fail++; $display("FAIL selchg_out_valid beat %0d got %b want ch%0d", i, out_valid, ch[i]); end
            n_checks++;
            if (out_data[ch[i]*DW +: DW] !== d[i]) begin n_fail++; $display("FAIL selchg_data beat %0d got %h want %h", i, out_data[ch[i]*DW +: DW], d[i]); end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 5'b11110;
        in_valid = 1'b1; in_data = 8'h51; in_last = 1'b0; sel = 3'd0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_first_ready got %b want 1", in_ready); end
        tick();
        in_data = 8'h52; sel = 3'd4;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready got %b want 0", in_ready); end
        for (int j = 0; j < 4; j++) begin
            tick();
            n_checks++;
            if (out_valid !== 5'b00001 || out_data[0 +: DW] !== 8'h51 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d got valid=%b data=%h ready=%b want 00001/51/0", j, out_valid, out_data[0 +: DW], in_ready);
            end
        end
        out_ready = 5'b11111;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
        tick();
        n_checks++;
        if (out_valid !== 5'b00001 || out_data[0 +: DW] !== 8'h52) begin n_fail++; $display("FAIL bp_second got valid=%b data=%h want 00001/52", out_valid, out_data[0 +: DW]); end
        in_data = 8'h53; in_last = 1'b1;
        tick();
        n_checks++;
        if (out_data[0 +: DW] !== 8'h53 || out_last !== 5'b00001) begin n_fail++; $display("FAIL bp_third got data=%h last=%b want 53/00001", out_data[0 +: DW], out_last); end
        idle_inputs();
        tick();
        n_checks++;
        if (out_valid !== 5'b0) begin n_fail++; $display("FAIL bp_drain got %b want 00000", out_valid); end
    endtask

    task automatic test_bad_sel();
        in_valid = 1'b1; in_data = 8'h61; in_last = 1'b0; sel = 3'd5;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bad_ready1 got %b want 1", in_ready); end
        tick();
        n_checks++;
        if (drop !== 1'b1 || out_valid !== 5'b0) begin n_fail++; $display("FAIL bad_beat1 got drop=%b valid=%b want 1/00000", drop, out_valid); end
        in_data = 8'h62; in_last = 1'b1; sel = 3'd0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bad_ready2 got %b want 1", in_ready); end
        tick();
        n_checks++;
        if (drop !== 1'b1 || out_valid !== 5'b0) begin n_fail++; $display("FAIL bad_beat2 got drop=%b valid=%b want 1/00000", drop, out_valid); end
        idle_inputs();
        tick();
        n_checks++;
        if (drop !== 1'b0) begin n_fail++; $display("FAIL bad_drop_end got %b want 0", drop); end
`ifdef STREAM_DEMUX_DROP_CNT_EN
        n_checks++;
        if (drop_cnt !== 16'd2) begin n_fail++; $display("FAIL bad_drop_cnt got %0d want 2", drop_cnt); end
`endif
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; in_data = 8'h71; in_last = 1'b0; sel = 3'd1;
        tick();
        n_checks++;
        if (out_valid !== 5'b00010) begin n_fail++; $display("FAIL rmid_beat1 got %b want 00010", out_valid); end
        in_data = 8'h72;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 5'b0 || out_last !== 5'b0) begin n_fail++; $display("FAIL rmid_async got valid=%b last=%b want 0/0", out_valid, out_last); end
        idle_inputs();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (out_valid !== 5'b0) begin n_fail++; $display("FAIL rmid_after_release got %b want 00000", out_valid); end
        in_valid = 1'b1; in_data = 8'h7A; in_last = 1'b1; sel = 3'd0;
        tick();
        n_checks++;
        if (out_valid !== 5'b00001 || out_data[0 +: DW] !== 8'h7A) begin n_fail++; $display("FAIL rmid_new_pkt got valid=%b data=%h want 00001/7a", out_valid, out_data[0 +: DW]); end
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        logic [11:0] sbq [$];
        logic [2:0]  pkt_sel = 3'd0;
        int          pkt_len = 1;
        int          beat_idx = 0;
        logic        acc;
        logic        found;
        for (int c = 0; c < 3000; c++) begin
            if (!in_valid && ($urandom_range(0, 3) != 0)) begin
                if (beat_idx == 0) begin
                    pkt_len = $urandom_range(1, 4);
                    pkt_sel = 3'($urandom_range(0, 6));
                    sel     = pkt_sel;
                end else begin
                    sel = 3'($urandom_range(0, 7));
                end
                in_data  = 8'($urandom);
                in_last  = (beat_idx == pkt_len - 1);
                in_valid = 1'b1;
            end
            out_ready = 5'($urandom);
            #1;
            acc = in_valid && in_ready;
            for (int k = 0; k < NO; k++) begin
                if (out_valid[k] && out_ready[k]) begin
                    found = 1'b0;
                    for (int i = 0; i < sbq.size() && !found; i++) begin
                        if (sbq[i][11:9] == 3'(k)) begin
                            found = 1'b1;
                            n_checks++;
                            if ({out_last[k], out_data[k*DW +: DW]} !== sbq[i][8:0]) begin
                                n_fail++;
                                $display("FAIL rand_beat ch%0d got last=%b data=%h want last=%b data=%h",
                                         k, out_last[k], out_data[k*DW +: DW], sbq[i][8], sbq[i][7:0]);
                            end
                            sbq.delete(i);
                        end
                    end
                    if (!found) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL rand_unexpected ch%0d got data=%h want no beat", k, out_data[k*DW +: DW]);
                    end
                end
            end
            tick();
            if (acc) begin
                if (pkt_sel < 3'd5) sbq.push_back({pkt_sel, in_last, in_data});
                beat_idx = in_last ? 0 : beat_idx + 1;
                in_valid = 1'b0;
            end
        end
        // Finish any open packet so the drain below sees everything.
        while (beat_idx != 0) begin
            in_valid = 1'b1; in_data = 8'hEE; in_last = 1'b1; out_ready = '1;
            if (pkt_sel < 3'd5) sbq.push_back({pkt_sel, 1'b1, 8'hEE});
            #1;
            if (in_ready) beat_idx = 0;
            else begin
                n_checks++; n_fail++;
                $display("FAIL rand_close got in_ready=%b want 1", in_ready);
                beat_idx = 0;
            end
            tick();
        end
        idle_inputs();
        for (int c = 0; c < 4; c++) begin
            #1;
            for (int k = 0; k < NO; k++) begin
                if (out_valid[k]) begin
                    found = 1'b0;
                    for (int i = 0; i < sbq.size() && !found; i++) begin
                        if (sbq[i][11:9] == 3'(k)) begin
                            found = 1'b1;
                            n_checks++;
                            if ({out_last[k], out_data[k*DW +: DW]} !== sbq[i][8:0]) begin
                                n_fail++;
                                $display("FAIL rand_drain ch%0d got data=%h want %h", k, out_data[k*DW +: DW], sbq[i][7:0]);
                            end
                            sbq.delete(i);
                        end
                    end
                    if (!found) begin
                        n_checks++; n_fail++;
                        $display("FAIL rand_drain_unexpected ch%0d got data=%h want no beat", k, out_data[k*DW +: DW]);
                    end
                end
            end
            tick();
        end
        n_checks++;
        if (sbq.size() != 0) begin n_fail++; $display("FAIL rand_leftover got %0d beats want 0", sbq.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sel_change();
        test_backpressure();
        test_bad_sel();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
